fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the CPU datapath: it owns the PC, issues requests to instruction memory and presents one fetched instruction at a time to decode.
- Supports instruction memory with variable latency through a req/valid handshake, and decode back-pressure through a valid/ready handshake.
- Redirects for branch and jump flush the fetch path; a request already in flight is drained safely before the new target is fetched.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, fetches from an
// instruction memory with variable latency, and presents one instruction at a
// time to decode. A redirect flushes the fetch path. If a request is still in
// flight, the stage waits for its response and discards it before fetching
// the new target.
//
// Handshakes:
//   imem: imem_req/imem_addr stay stable until imem_valid is seen with
//         imem_req high. The cycle with imem_req && imem_valid completes
//         the fetch. imem_valid may arrive in the same cycle as imem_req.
//   decode: if_valid/if_instr/if_pc stay stable until id_ready is seen with
//         if_valid high. The cycle with if_valid && id_ready is the transfer.
//
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched and perf_stall
// saturating counters.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    input  logic              id_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [1:0]        dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_target_pc;
    logic              r_outstanding;
    logic              r_if_valid;
    logic [31:0]       r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;

    logic              w_transfer;
    logic              w_slot_free;
    logic              w_req;
    logic              w_complete;
    logic [ADDR_W-1:0] w_redirect_pc;

    // Redirect targets are word aligned, so the low two bits are dropped.
    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);

    // Request generation from the current state and decode handshake.
    always_comb begin
        w_transfer  = r_if_valid && id_ready;
        w_slot_free = !r_if_valid || w_transfer;
        w_req       = 1'b0;
        case (r_state)
            ST_RUN:   w_req = r_outstanding || w_slot_free;
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
        w_complete  = w_req && imem_valid;
    end

    // Fetch FSM: PC, in-flight tracking, redirect handling and output register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_target_pc   <= RESET_PC;
            r_outstanding <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
        end else begin
            // A request stays outstanding until its response arrives. In BOOT,
            // w_req is 0, so a stray imem_valid leaves this flag cleared.
            r_outstanding <= w_req && !imem_valid;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        r_if_valid <= 1'b0;
                        if (w_req && !imem_valid) begin
                            // Memory holds the old request. Wait for that
                            // response before moving to the new target.
                            r_target_pc <= w_redirect_pc;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_fetch_pc <= w_redirect_pc;
                        end
                    end else if (w_complete) begin
                        r_if_instr <= imem_rdata;
                        r_if_pc    <= r_fetch_pc;
                        r_if_valid <= 1'b1;
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                    end else if (w_transfer) begin
                        r_if_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_if_valid <= 1'b0;
                    if (imem_valid) begin
                        // Drop the stale data. If a redirect arrives in this
                        // cycle, it is the most recent target and is used.
                        r_fetch_pc <= redirect ? w_redirect_pc : r_target_pc;
                        r_state    <= ST_RUN;
                    end else if (redirect) begin
                        r_target_pc <= w_redirect_pc;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc + ADDR_W'(4);
    assign dbg_state   = r_state;

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == ST_RUN) && w_req && !imem_valid;

    // Saturating counts of accepted instructions and memory wait cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_transfer && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (w_stall && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    // Without the feature, there are no counters and no perf ports.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A vector table covers the
// zero-latency stream. Hand-written sequences cover latency, redirect drain,
// and clear-mid-wait. Checks on the FETCH_PERF_EN counters are compiled in
// only when the macro is defined.
module tb_fetch_stage;

  logic        clk;
  logic        clr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [7:0]  if_pc_plus4;
  logic        id_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  fetch_stage #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .clr         (clr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_state   (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  // ---------------- memory model ----------------
  // imem_valid rises when a held request has waited mem_lat cycles.
  // mem_force injects a stray response.
  int unsigned mem_lat   = 0;
  int unsigned wait_cnt  = 0;
  logic        mem_force = 1'b0;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, 8'h00, a};
  endfunction

  always @(posedge clk) begin
    if (!imem_req || imem_valid) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  assign imem_valid = mem_force || (imem_req && (wait_cnt == mem_lat));
  assign imem_rdata = mem_force ? 32'hBAD0BAD0 : mem_word(imem_addr);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare each accepted instruction against the expected PC stream.
  always @(negedge clk) begin
    if (mon_en && !clr && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_transfer", {24'h0, if_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_transfer_pc", {24'h0, if_pc}, {24'h0, e});
        chk("sb_transfer_instr", if_instr, mem_word(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into the BOOT cycle that follows reset.
  task automatic do_reset();
    clr         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    id_ready    = 1'b1;
    mem_force   = 1'b0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // Called 2ns after an edge. Advances the clock until if_valid is seen or
  // the cycle budget runs out.
  task automatic wait_if_valid(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (if_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: if_valid=0 expected 1 within %0d cycles", name, budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       id_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic       exp_req;
    logic [7:0] exp_addr;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Zero-latency memory. Inputs apply in this cycle; outputs are for this cycle.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0}; // BOOT
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h04, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h08, 2'd1}; // stall
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h08, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h08, 2'd1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h08, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h0C, 2'd1};
    vecs[8]  = '{1'b1, 1'b1, 8'h43, 1'b1, 8'h0C, 1'b1, 8'h10, 2'd1}; // redirect, unaligned
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0C, 1'b1, 8'h40, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 8'h44, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 8'hF8, 1'b1, 8'h44, 1'b1, 8'h48, 2'd1};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 8'hF8, 2'd1};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hF8, 1'b1, 8'hFC, 2'd1};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFC, 1'b1, 8'h00, 2'd1}; // wrap
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h04, 2'd1};

    // ---- reset state ----
    clr = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    id_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", {24'h0, if_pc}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);

    // ---- table: zero-latency stream, stall, redirects, wrap ----
    mem_lat = 0;
    do_reset();
    exp_q = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'hF8, 8'hFC, 8'h00};
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e4;
      id_ready    = vecs[i].id_ready;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].redirect_pc;
      #1;
      e4 = vecs[i].exp_pc + 8'd4;
      chk($sformatf("v%0d_if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_if_pc", i), {24'h0, if_pc}, {24'h0, vecs[i].exp_pc});
      chk($sformatf("v%0d_if_pc_plus4", i), {24'h0, if_pc_plus4}, {24'h0, e4});
      chk($sformatf("v%0d_imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
      chk($sformatf("v%0d_imem_addr", i), {24'h0, imem_addr}, {24'h0, vecs[i].exp_addr});
      chk($sformatf("v%0d_state", i), {30'h0, dbg_state}, {30'h0, vecs[i].exp_state});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_if_instr", i), if_instr, mem_word(vecs[i].exp_pc));
      end
      tick();
    end
    redirect = 1'b0;
    mon_en = 1'b0;
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    // ---- 3-cycle latency, redirect in second wait cycle of fetch 0x08 ----
    do_reset();
    mem_lat = 2;
    repeat (7) tick();                       // c7
    #1;
    chk("lat_c7_if_pc", {24'h0, if_pc}, 32'h04);
    chk("lat_c7_imem_addr", {24'h0, imem_addr}, 32'h08);
    tick();                                  // c8: second wait cycle
    redirect = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("lat_c8_imem_addr", {24'h0, imem_addr}, 32'h08);
    chk("lat_c8_imem_valid", {31'h0, imem_valid}, 32'h0);
    tick();                                  // c9: drain completes
    redirect = 1'b0;
    #1;
    chk("lat_c9_state", {30'h0, dbg_state}, 32'd2);
    chk("lat_c9_imem_addr", {24'h0, imem_addr}, 32'h08);
    chk("lat_c9_imem_valid", {31'h0, imem_valid}, 32'h1);
    tick();                                  // c10
    #1;
    chk("lat_c10_state", {30'h0, dbg_state}, 32'd1);
    chk("lat_c10_if_valid", {31'h0, if_valid}, 32'h0);
    chk("lat_c10_imem_addr", {24'h0, imem_addr}, 32'h40);
    wait_if_valid(8, "lat_wait_valid");
    chk("lat_next_if_pc", {24'h0, if_pc}, 32'h40);
    chk("lat_next_if_instr", if_instr, mem_word(8'h40));

    // ---- two redirects during DRAIN: latest wins ----
    do_reset();
    mem_lat = 4;
    tick();                                  // c1: request 0x00, w0
    tick();                                  // c2: w1
    redirect = 1'b1;
    redirect_pc = 8'h20;
    tick();                                  // c3: DRAIN, w2
    redirect_pc = 8'h30;
    #1;
    chk("drn_c3_state", {30'h0, dbg_state}, 32'd2);
    chk("drn_c3_imem_req", {31'h0, imem_req}, 32'h1);
    tick();                                  // c4: w3
    redirect = 1'b0;
    #1;
    chk("drn_c4_imem_addr", {24'h0, imem_addr}, 32'h00);
    chk("drn_c4_if_valid", {31'h0, if_valid}, 32'h0);
    tick();                                  // c5: response arrives
    #1;
    chk("drn_c5_imem_valid", {31'h0, imem_valid}, 32'h1);
    tick();                                  // c6
    #1;
    chk("drn_c6_imem_addr", {24'h0, imem_addr}, 32'h30);
    wait_if_valid(12, "drn_wait_valid");
    chk("drn_if_pc", {24'h0, if_pc}, 32'h30);

    // ---- clr mid-wait, late response ignored ----
    do_reset();
    mem_lat = 1;
    tick();
    tick();
    tick();                                  // c3: valid 0x00, request 0x04 waiting
    #1;
    chk("clr_pre_if_valid", {31'h0, if_valid}, 32'h1);
    chk("clr_pre_imem_addr", {24'h0, imem_addr}, 32'h04);
    clr = 1'b1;
    tick();                                  // c4: BOOT after clear
    clr = 1'b0;
    mem_force = 1'b1;
    #1;
    chk("clr_if_valid", {31'h0, if_valid}, 32'h0);
    chk("clr_if_pc", {24'h0, if_pc}, 32'h0);
    chk("clr_if_instr", if_instr, 32'h0);
    chk("clr_imem_req", {31'h0, imem_req}, 32'h0);
    chk("clr_imem_addr", {24'h0, imem_addr}, 32'h00);
    chk("clr_state", {30'h0, dbg_state}, 32'd0);
    tick();                                  // c5
    mem_force = 1'b0;
    #1;
    chk("clr_c5_state", {30'h0, dbg_state}, 32'd1);
    chk("clr_c5_if_valid", {31'h0, if_valid}, 32'h0);
    chk("clr_c5_imem_req", {31'h0, imem_req}, 32'h1);
    chk("clr_c5_imem_addr", {24'h0, imem_addr}, 32'h00);
    wait_if_valid(8, "clr_wait_valid");
    chk("clr_restart_if_pc", {24'h0, if_pc}, 32'h00);
    chk("clr_restart_if_instr", if_instr, mem_word(8'h00));

`ifdef FETCH_PERF_EN
    // ---- perf counters: 5 transfers, 2-cycle latency ----
    do_reset();
    #1;
    chk("perf_rst_fetched", {16'h0, perf_fetched}, 32'd0);
    chk("perf_rst_stall", {16'h0, perf_stall}, 32'd0);
    mem_lat = 1;
    repeat (11) tick();                      // c11: fifth transfer
    mem_lat = 0;                             // next fetch completes at once
    tick();
    id_ready = 1'b0;
    #1;
    chk("perf_fetched", {16'h0, perf_fetched}, 32'd5);
    chk("perf_stall", {16'h0, perf_stall}, 32'd5);
    id_ready = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
